// File: rtl/pd_power_sequencer_if.sv
// Request handshake and domain-control bundle between a power manager and one
// power-gated domain sequencer.
interface pd_power_sequencer_if;
    logic       req_valid_i;
    logic       req_on_i;
    logic       req_ready_o;
    logic       switch_ack_i;
    logic       switch_o;
    logic       iso_o;
    logic       dom_rst_o;
    logic       clk_en_o;
    logic       done_o;
    logic       fault_o;
    logic       fault_clr_i;
    logic [3:0] state_o;

    modport slave (
        input  req_valid_i, req_on_i, switch_ack_i, fault_clr_i,
        output req_ready_o, switch_o, iso_o, dom_rst_o, clk_en_o, done_o, fault_o, state_o
    );

    modport master (
        output req_valid_i, req_on_i, switch_ack_i, fault_clr_i,
        input  req_ready_o, switch_o, iso_o, dom_rst_o, clk_en_o, done_o, fault_o, state_o
    );
endinterface

// File: rtl/pd_power_sequencer.sv
// Power-down / power-up sequencer for one gated domain: switch, isolation, reset
// and clock-gate control with a synchronised switch acknowledge and ack timeout.
module pd_power_sequencer #(
    parameter int RESET_ON        = 1,
    parameter int CLK_WAIT        = 2,
    parameter int ISO_WAIT        = 2,
    parameter int RST_WAIT        = 4,
    parameter int ACK_TIMEOUT     = 32,
    parameter int ACK_SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pd_power_sequencer_if.slave pif
);
    localparam int MAX_A = (CLK_WAIT > ISO_WAIT) ? CLK_WAIT : ISO_WAIT;
    localparam int MAX_B = (RST_WAIT > ACK_TIMEOUT) ? RST_WAIT : ACK_TIMEOUT;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] CLK_LOAD = CNT_W'(CLK_WAIT - 1);
    localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_WAIT - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic             RESET_LVL = (RESET_ON != 0);

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_SW_ON   = 4'd1,
        ST_ISO_OFF = 4'd2,
        ST_CLK_ON  = 4'd3,
        ST_ON      = 4'd4,
        ST_CLK_OFF = 4'd5,
        ST_ISO_ON  = 4'd6,
        ST_RST_ON  = 4'd7,
        ST_SW_OFF  = 4'd8,
        ST_FAULT   = 4'd9
    } state_t;

    localparam state_t RESET_STATE = (RESET_ON != 0) ? ST_ON : ST_OFF;

    // Control vector {switch, iso, dom_rst, clk_en}; unknown codes fall back to the safe OFF pattern.
    function automatic logic [3:0] ctrl_decode(input state_t st);
        logic [3:0] v;
        case (st)
            ST_OFF:     v = 4'b0110;
            ST_SW_ON:   v = 4'b1110;
            ST_ISO_OFF: v = 4'b1010;
            ST_CLK_ON:  v = 4'b1011;
            ST_ON:      v = 4'b1001;
            ST_CLK_OFF: v = 4'b1000;
            ST_ISO_ON:  v = 4'b1100;
            ST_RST_ON:  v = 4'b1110;
            ST_SW_OFF:  v = 4'b0110;
            ST_FAULT:   v = 4'b0110;
            default:    v = 4'b0110;
        endcase
        return v;
    endfunction

    state_t                     state_r;
    state_t                     state_next;
    logic [ACK_SYNC_STAGES-1:0] sync_r;
    logic                       ack_s;
    logic [CNT_W-1:0]           wait_cnt_r;
    logic [CNT_W-1:0]           tmo_cnt_r;
    logic [CNT_W-1:0]           wait_load_val_s;
    logic                       wait_load_s;
    logic                       wait_zero_s;
    logic                       tmo_expired_s;
    logic                       done_next_s;
    logic [3:0]                 ctrl_r;
    logic                       ready_r;
    logic                       done_r;
    logic                       fault_r;

    assign ack_s         = sync_r[ACK_SYNC_STAGES-1];
    assign wait_zero_s   = (wait_cnt_r == '0);
    assign tmo_expired_s = (tmo_cnt_r == TMO_LAST);

    // Switch-ack synchroniser chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_r <= {ACK_SYNC_STAGES{RESET_LVL}};
        end else begin
            sync_r[0] <= pif.switch_ack_i;
            for (int i = 1; i < ACK_SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; a valid ack beats an expiring timeout in the same cycle.
    always_comb begin
        state_next      = state_r;
        wait_load_s     = 1'b0;
        wait_load_val_s = '0;
        done_next_s     = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (pif.req_valid_i) begin
                    if (pif.req_on_i) begin
                        state_next = ST_SW_ON;
                    end else begin
                        done_next_s = 1'b1;
                    end
                end else begin
                    state_next = ST_OFF;
                end
            end
            ST_ON: begin
                if (pif.req_valid_i) begin
                    if (!pif.req_on_i) begin
                        state_next      = ST_CLK_OFF;
                        wait_load_s     = 1'b1;
                        wait_load_val_s = CLK_LOAD;
                    end else begin
                        done_next_s = 1'b1;
                    end
                end else begin
                    state_next = ST_ON;
                end
            end
            ST_CLK_OFF: begin
                if (wait_zero_s) begin
                    state_next      = ST_ISO_ON;
                    wait_load_s     = 1'b1;
                    wait_load_val_s = ISO_LOAD;
                end else begin
                    state_next = ST_CLK_OFF;
                end
            end
            ST_ISO_ON: begin
                if (wait_zero_s) begin
                    state_next = ST_RST_ON;
                end else begin
                    state_next = ST_ISO_ON;
                end
            end
            ST_RST_ON: begin
                state_next = ST_SW_OFF;
            end
            ST_SW_OFF: begin
                if (!ack_s) begin
                    state_next  = ST_OFF;
                    done_next_s = 1'b1;
                end else if (tmo_expired_s) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next = ST_SW_OFF;
                end
            end
            ST_SW_ON: begin
                if (ack_s) begin
                    state_next      = ST_ISO_OFF;
                    wait_load_s     = 1'b1;
                    wait_load_val_s = ISO_LOAD;
                end else if (tmo_expired_s) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next = ST_SW_ON;
                end
            end
            ST_ISO_OFF: begin
                if (wait_zero_s) begin
                    state_next      = ST_CLK_ON;
                    wait_load_s     = 1'b1;
                    wait_load_val_s = RST_LOAD;
                end else begin
                    state_next = ST_ISO_OFF;
                end
            end
            ST_CLK_ON: begin
                if (wait_zero_s) begin
                    state_next  = ST_ON;
                    done_next_s = 1'b1;
                end else begin
                    state_next = ST_CLK_ON;
                end
            end
            ST_FAULT: begin
                if (pif.fault_clr_i) begin
                    state_next = ST_OFF;
                end else begin
                    state_next = ST_FAULT;
                end
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    // Phase wait counter: loaded on entry, counts down to zero and holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_r <= '0;
        end else if (wait_load_s) begin
            wait_cnt_r <= wait_load_val_s;
        end else if (!wait_zero_s) begin
            wait_cnt_r <= wait_cnt_r - CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Ack timeout counter: held at zero outside the switch states, saturates at the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_r <= '0;
        end else if ((state_r != ST_SW_ON) && (state_r != ST_SW_OFF)) begin
            tmo_cnt_r <= '0;
        end else if (!tmo_expired_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Output registers decoded from the upcoming state so they track state_r exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_r  <= ctrl_decode(RESET_STATE);
            ready_r <= 1'b1;
            fault_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ctrl_r  <= ctrl_decode(state_next);
            ready_r <= (state_next == ST_ON) || (state_next == ST_OFF);
            fault_r <= (state_next == ST_FAULT);
            done_r  <= done_next_s;
        end
    end

    assign pif.switch_o    = ctrl_r[3];
    assign pif.iso_o       = ctrl_r[2];
    assign pif.dom_rst_o   = ctrl_r[1];
    assign pif.clk_en_o    = ctrl_r[0];
    assign pif.req_ready_o = ready_r;
    assign pif.done_o      = done_r;
    assign pif.fault_o     = fault_r;
    assign pif.state_o     = state_r;
endmodule

// File: tb/tb_pd_power_sequencer.sv
// Scoreboard bench for pd_power_sequencer: a timing model predicts every state
// change / done / fault event, a negedge monitor consumes and compares them.
module tb_pd_power_sequencer;
    localparam int CW = 2, IW = 2, RW = 4, TO = 32, SS = 2;
    localparam int S_OFF = 0, S_SW_ON = 1, S_ISO_OFF = 2, S_CLK_ON = 3, S_ON = 4;
    localparam int S_CLK_OFF = 5, S_ISO_ON = 6, S_RST_ON = 7, S_SW_OFF = 8, S_FAULT = 9;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic       done;
        logic       fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat = 15;
    bit          ack_force = 1'b0;
    bit          mon_en = 1'b0;
    int          m_st = 1;      // model: 0 OFF, 1 ON, 2 FAULT
    logic [63:0] hist = '1;
    logic [3:0]  prev_st;
    logic        prev_fault;
    exp_t        q[$];

    pd_power_sequencer_if pif ();

    pd_power_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .pif   (pif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Switch-cell model: ack in cycle c equals switch_o in cycle c-lat.
    always @(posedge clk) begin
        #1;
        hist <= {hist[62:0], (rst ? 1'b1 : pif.switch_o)};
        pif.switch_ack_i <= ack_force ? 1'b1 : hist[lat-1];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // {switch, iso, dom_rst, clk_en, ready, fault} for each state code
    function automatic logic [5:0] exp_outs(input logic [3:0] s);
        case (s)
            4'd0:    return 6'b011010;
            4'd1:    return 6'b111000;
            4'd2:    return 6'b101000;
            4'd3:    return 6'b101100;
            4'd4:    return 6'b100110;
            4'd5:    return 6'b100000;
            4'd6:    return 6'b110000;
            4'd7:    return 6'b111000;
            4'd8:    return 6'b011000;
            4'd9:    return 6'b011001;
            default: return 6'bxxxxxx;
        endcase
    endfunction

    function automatic void push(input int c, input int st, input bit d, input bit f);
        exp_t e;
        e.cyc = c; e.st = 4'(st); e.done = d; e.fault = f;
        q.push_back(e);
    endfunction

    // Timing model: request accepted at cycle t.
    function automatic void predict(input bit on, input int t);
        int e;
        int a;
        bit ack_ok;
        ack_ok = !ack_force && (lat + SS <= TO - 1);
        if ((on && m_st == 1) || (!on && m_st == 0)) begin
            push(t + 1, on ? S_ON : S_OFF, 1'b1, 1'b0);
        end else if (on) begin
            e = t + 1;
            push(e, S_SW_ON, 1'b0, 1'b0);
            if (ack_ok) begin
                a = e + lat + SS + 1;
                push(a, S_ISO_OFF, 1'b0, 1'b0);
                push(a + IW, S_CLK_ON, 1'b0, 1'b0);
                push(a + IW + RW, S_ON, 1'b1, 1'b0);
                m_st = 1;
            end else begin
                push(e + TO, S_FAULT, 1'b0, 1'b1);
                m_st = 2;
            end
        end else begin
            push(t + 1, S_CLK_OFF, 1'b0, 1'b0);
            push(t + 1 + CW, S_ISO_ON, 1'b0, 1'b0);
            push(t + 1 + CW + IW, S_RST_ON, 1'b0, 1'b0);
            e = t + 2 + CW + IW;
            push(e, S_SW_OFF, 1'b0, 1'b0);
            if (ack_ok) begin
                push(e + lat + SS + 1, S_OFF, 1'b1, 1'b0);
                m_st = 0;
            end else begin
                push(e + TO, S_FAULT, 1'b0, 1'b1);
                m_st = 2;
            end
        end
    endfunction

    // Monitor: every state change, done pulse or fault rise consumes one expected event.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("moore_outputs",
                  {26'd0, pif.switch_o, pif.iso_o, pif.dom_rst_o, pif.clk_en_o, pif.req_ready_o, pif.fault_o},
                  {26'd0, exp_outs(pif.state_o)});
            if ((pif.state_o != prev_st) || pif.done_o || (pif.fault_o && !prev_fault)) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: state %0d done %0b fault %0b at cycle %0d, none expected",
                             pif.state_o, pif.done_o, pif.fault_o, cyc);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_state", {28'd0, pif.state_o}, {28'd0, e.st});
                    check("event_done", {31'd0, pif.done_o}, {31'd0, e.done});
                    check("event_fault", {31'd0, pif.fault_o}, {31'd0, e.fault});
                end
            end
        end
        prev_st    <= pif.state_o;
        prev_fault <= pif.fault_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic request(input bit on, output int t);
        int budget = 100;
        step();
        while (!pif.req_ready_o && budget > 0) begin
            step();
            budget--;
        end
        t = cyc;
        if (budget == 0) begin
            check("ready_wait_timeout", 32'd0, 32'd1);
        end else begin
            pif.req_valid_i = 1'b1;
            pif.req_on_i    = on;
            predict(on, t);
            step();
            pif.req_valid_i = 1'b0;
            pif.req_on_i    = 1'b0;
        end
    endtask

    task automatic drain();
        int budget = 300;
        while (q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            check("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic clear_fault();
        if (m_st == 2) begin
            step();
            pif.fault_clr_i = 1'b1;
            push(cyc + 1, S_OFF, 1'b0, 1'b0);
            step();
            pif.fault_clr_i = 1'b0;
            m_st = 0;
            drain();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit on;
        int r;
        pif.req_valid_i = 1'b0;
        pif.req_on_i    = 1'b0;
        pif.fault_clr_i = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {28'd0, pif.state_o}, 32'd4);
        check("reset_done", {31'd0, pif.done_o}, 32'd0);
        check("reset_fault", {31'd0, pif.fault_o}, 32'd0);
        check("reset_outs", {26'd0, pif.switch_o, pif.iso_o, pif.dom_rst_o, pif.clk_en_o,
                             pif.req_ready_o, pif.fault_o}, 32'h26);
        mon_en = 1'b1;
        idle(40);

        // nominal power-down then power-up
        request(1'b0, t); drain(); idle(40);
        request(1'b1, t); drain(); idle(10);

        // redundant ON request
        request(1'b1, t); drain(); idle(5);

        // request poked during ISO_ON is refused and changes nothing
        request(1'b0, t);
        step(); step();
        pif.req_valid_i = 1'b1;
        pif.req_on_i    = 1'b1;
        check("ready_in_iso_on", {31'd0, pif.req_ready_o}, 32'd0);
        step();
        pif.req_valid_i = 1'b0;
        pif.req_on_i    = 1'b0;
        drain(); idle(40);
        request(1'b1, t); drain(); idle(40);

        // ack stuck high during power-down
        ack_force = 1'b1;
        request(1'b0, t); drain();
        clear_fault();
        ack_force = 1'b0;
        idle(40);

        // ack on the last timeout cycle wins; one cycle later faults
        lat = 29; request(1'b1, t); drain(); idle(40);
        lat = 30; request(1'b0, t); drain(); clear_fault(); idle(40);
        lat = 30; request(1'b1, t); drain(); clear_fault(); idle(40);
        lat = 29; request(1'b1, t); drain(); idle(40);

        // synchronous reset in the middle of ISO_ON
        lat = 15;
        request(1'b0, t);
        step(); step();
        rst = 1'b1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc > t + 3) q.delete(i);
        end
        push(t + 4, S_ON, 1'b0, 1'b0);
        m_st = 1;
        step();
        rst = 1'b0;
        drain(); idle(40);
        request(1'b0, t); drain(); idle(40);
        request(1'b1, t); drain(); idle(40);

        // randomized requests
        for (int k = 0; k < 25; k++) begin
            on = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            if (r < 7) lat = int'($urandom_range(1, 24));
            else if (r == 7) lat = 29;
            else if (r == 8) lat = 30;
            else begin
                lat = 15;
                if (!on && m_st == 1) ack_force = 1'b1;
            end
            request(on, t);
            drain();
            clear_fault();
            ack_force = 1'b0;
            idle(40);
        end

        drain();
        check("scoreboard_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
